// File: rtl/ctrl_word_skid_stage.sv
// Decode-to-execute control word stage: a main output register backed by one skid
// register, with flush, NOP insertion and a saturating count of flushed entries.
module ctrl_word_skid_stage #(
  parameter int              CW_W   = 16,
  parameter int              PC_W   = 32,
  parameter logic [CW_W-1:0] CW_NOP = '0,
  parameter int              CNT_W  = 8
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CW_W-1:0]  in_cw,
  input  logic [PC_W-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW_W-1:0]  out_cw,
  output logic [PC_W-1:0]  out_pc,
  input  logic             flush,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] flush_kills
);

  // Adds 0..3 to the kill counter; the carry out of the widened sum marks overflow.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [1:0]       inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + {{(CNT_W-1){1'b0}}, inc};
    if (sum[CNT_W]) begin
      return {CNT_W{1'b1}};
    end else begin
      return sum[CNT_W-1:0];
    end
  endfunction

  logic             main_valid_q, main_valid_d;
  logic [CW_W-1:0]  main_cw_q,    main_cw_d;
  logic [PC_W-1:0]  main_pc_q,    main_pc_d;
  logic             skid_valid_q, skid_valid_d;
  logic [CW_W-1:0]  skid_cw_q,    skid_cw_d;
  logic [PC_W-1:0]  skid_pc_q,    skid_pc_d;
  logic             in_ready_q,   in_ready_d;
  logic [1:0]       occ_q,        occ_d;
  logic [CNT_W-1:0] kills_q,      kills_d;

  logic       in_xfer;
  logic       out_xfer;
  logic [1:0] kill_inc;

  assign in_xfer  = in_valid && in_ready_q;
  assign out_xfer = main_valid_q && out_ready;

  // Next-state for both registers: flush wins, otherwise FIFO refill of main from skid then input.
  always_comb begin
    main_valid_d = main_valid_q;
    main_cw_d    = main_cw_q;
    main_pc_d    = main_pc_q;
    skid_valid_d = skid_valid_q;
    skid_cw_d    = skid_cw_q;
    skid_pc_d    = skid_pc_q;
    kills_d      = kills_q;
    kill_inc     = 2'd0;
    if (flush) begin
      // An entry leaving through the output this cycle was consumed, so it is not a kill.
      kill_inc     = {1'b0, main_valid_q && !out_ready} + {1'b0, skid_valid_q} + {1'b0, in_xfer};
      kills_d      = sat_add(kills_q, kill_inc);
      main_valid_d = 1'b0;
      main_cw_d    = CW_NOP;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || out_xfer) begin
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_cw_d    = skid_cw_q;
        main_pc_d    = skid_pc_q;
        skid_valid_d = in_xfer;
        if (in_xfer) begin
          skid_cw_d = in_cw;
          skid_pc_d = in_pc;
        end else begin
          skid_cw_d = skid_cw_q;
          skid_pc_d = skid_pc_q;
        end
      end else if (in_xfer) begin
        main_valid_d = 1'b1;
        main_cw_d    = in_cw;
        main_pc_d    = in_pc;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = 1'b0;
        main_cw_d    = CW_NOP;
        skid_valid_d = 1'b0;
      end
    end else begin
      if (in_xfer) begin
        skid_valid_d = 1'b1;
        skid_cw_d    = in_cw;
        skid_pc_d    = in_pc;
      end else begin
        skid_valid_d = skid_valid_q;
      end
    end
    in_ready_d = !skid_valid_d;
    occ_d      = {1'b0, main_valid_d} + {1'b0, skid_valid_d};
  end

  // State registers; every output is taken straight from one of these flops.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      main_valid_q <= 1'b0;
      main_cw_q    <= CW_NOP;
      main_pc_q    <= {PC_W{1'b0}};
      skid_valid_q <= 1'b0;
      skid_cw_q    <= CW_NOP;
      skid_pc_q    <= {PC_W{1'b0}};
      in_ready_q   <= 1'b1;
      occ_q        <= 2'd0;
      kills_q      <= {CNT_W{1'b0}};
    end else begin
      main_valid_q <= main_valid_d;
      main_cw_q    <= main_cw_d;
      main_pc_q    <= main_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_cw_q    <= skid_cw_d;
      skid_pc_q    <= skid_pc_d;
      in_ready_q   <= in_ready_d;
      occ_q        <= occ_d;
      kills_q      <= kills_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = main_valid_q;
  assign out_cw      = main_cw_q;
  assign out_pc      = main_pc_q;
  assign occupancy   = occ_q;
  assign flush_kills = kills_q;

endmodule
